serial_subtractor: RTL and testbench

- Bit-serial multi-bit subtractor: computes diff = a - b one bit per clock, LSB first.
- Uses a single full-adder cell: b is inverted and the initial carry is 1 (two's-complement subtraction).
- Sits beside the combinational full-adder labs as the sequential counterpart: it reuses the adder cell and runs it in the opposite, subtracting direction.
- Driven by a start/done handshake from a lab top level or a switch/LED wrapper.

---
 rtl/serial_sub_pkg.sv | 16 +
 rtl/serial_subtractor_fa_cell.sv | 15 +
 rtl/serial_subtractor.sv | 93 +++++++++
 tb/tb_serial_subtractor.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding, default width and adder helper for serial_subtractor
package serial_sub_pkg;

  localparam int SUB_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sub_state_t;

  function automatic logic majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_subtractor_fa_cell.sv
// rtl/serial_subtractor_fa_cell.sv - combinational full-adder cell (module fa_cell)
module fa_cell
  import serial_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = majority(a, b, cin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b, LSB first, one full-adder cell with inverted b
// Optional signed-overflow output ovf enabled by macro SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sub_state_t     state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             cout;

  fa_cell u_fa (
    .a    (a_sh[0]),
    .b    (~b_sh[0]),
    .cin  (carry),
    .s    (s),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= 1'b1;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          // Result bits back-fill the minuend register from the MSB side as it drains.
          a_sh  <= {s, a_sh[WIDTH-1:1]};
          b_sh  <= b_sh >> 1;
          carry <= cout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            diff   <= {s, a_sh[WIDTH-1:1]};
            borrow <= ~cout;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= carry ^ cout;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized and directed self-checking bench for serial_subtractor
module tb_serial_subtractor;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;
  localparam int HALF = 1 << (W - 1);

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= HALF) ? v - (1 << W) : v;
  endfunction

  // One full operation: checks latency, busy length, single done pulse and result.
  task automatic run_op(input int ai, input int bi, input string tag);
    int done_at = -1;
    int n_done  = 0;
    int n_busy  = 0;
    int sd;
    logic [W-1:0] got_d = '0;
    logic         got_b = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    logic         got_o = 1'b0;
`endif
    @(posedge clk); #1;
    start = 1'b1; a = W'(ai); b = W'(bi);
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    if (busy) n_busy++;
    for (int k = 1; k <= W + 3; k++) begin
      @(posedge clk); #1;
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        if (done_at < 0) begin
          done_at = k;
          got_d = diff;
          got_b = borrow;
`ifdef SERIAL_SUB_OVF_EN
          got_o = ovf;
`endif
        end
      end
    end
    check({tag, "_latency"}, done_at, W);
    check({tag, "_ndone"}, n_done, 1);
    check({tag, "_busy"}, n_busy, W);
    check({tag, "_diff"}, got_d, (ai - bi) & MASK);
    check({tag, "_borrow"}, got_b, (ai < bi) ? 1 : 0);
    sd = to_signed(ai) - to_signed(bi);
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, got_o, (sd > HALF - 1 || sd < -HALF) ? 1 : 0);
`else
    if (sd == 0) sd = 0;
`endif
  endtask

  initial begin
    int dq_k[$];
    int dq_d[$];
    int n_done;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
    rst = 1'b0;

    run_op(9, 3, "d9m3");
    run_op(3, 9, "d3m9");
    run_op(0, 0, "d0m0");
    run_op(15, 15, "d15m15");
    run_op(0, MASK, "d0mmax");
    run_op(7, 8, "d7m8");
    run_op(5, 2, "d5m2");

    // Ignored start during RUN, then back-to-back accept from DONE.
    @(posedge clk); #1;
    start = 1'b1; a = 5; b = 2;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (done) begin
        dq_k.push_back(k);
        dq_d.push_back(int'(diff));
      end
      if (k == 1) begin start = 1'b1; a = 1; b = 1; end
      if (k == 2) start = 1'b0;
      if (k == 4) begin start = 1'b1; a = 8; b = 1; end
      if (k == 5) start = 1'b0;
    end
    check("b2b_ndone", dq_k.size(), 2);
    if (dq_k.size() >= 1) begin
      check("b2b_first_at", dq_k[0], W);
      check("b2b_first_diff", dq_d[0], 3);
    end
    if (dq_k.size() >= 2) begin
      check("b2b_second_at", dq_k[1], 2 * W + 1);
      check("b2b_second_diff", dq_d[1], 7);
    end

    // Reset on the second RUN cycle aborts without a done.
    @(posedge clk); #1;
    start = 1'b1; a = 12; b = 4;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", diff, 0);
    check("abort_borrow", borrow, 0);
    n_done = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("abort_nodone", n_done, 0);

    for (int ai = 0; ai <= MASK; ai++)
      for (int bi = 0; bi <= MASK; bi++)
        run_op(ai, bi, "sweep");

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      run_op(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
